// File: rtl/usr_pkg.sv
// usr_deser32 shared constants and FSM state type.
// Used by usr_deser32 and usr_deser_shift.
package usr_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   localparam logic DIR_MSB = 1'b0;
   localparam logic DIR_LSB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_t;

endpackage

// File: rtl/usr_deser_shift.sv
// Serial-in shift register with per-word direction.
// word presents the next shifted value, or the held sreg when peek is set.
module usr_deser_shift
   import usr_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             dir,
   input  logic             sin,
   input  logic             peek,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic [WIDTH-1:0] shift_val;

   // next shift value for the active direction; clear/shift/hold select
   always_comb begin
      shift_val = {sreg_q[WIDTH-2:0], sin};
      if (dir == DIR_LSB) begin
         shift_val = {sin, sreg_q[WIDTH-1:1]};
      end
      sreg_d = sreg_q;
      if (clr) begin
         sreg_d = '0;
      end else if (shift_en) begin
         sreg_d = shift_val;
      end
      word = peek ? sreg_q : shift_val;
   end

   // shift register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

endmodule

// File: rtl/usr_deser32.sv
// 32-bit serial-to-parallel deserializer with output handshake.
// Optional even parity bit per word: define USR_DESER_PARITY_EN.
module usr_deser32
   import usr_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             dir,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             parity_err
);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             dir_q;
   logic             dir_d;
   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] dout_d;
   logic             dout_valid_q;
   logic             dout_valid_d;
   logic             overrun_q;
   logic             overrun_d;

   logic             eff_dir;
   logic             shift_en;
   logic             clr;
   logic             complete;
   logic             peek;
   logic [WIDTH-1:0] word;

   // first bit of a word uses the live dir; later bits use the latched one
   assign eff_dir = (state_q == IDLE) ? dir : dir_q;
   assign peek    = (state_q == PAR);

   usr_deser_shift u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .shift_en (shift_en),
      .dir      (eff_dir),
      .sin      (sin),
      .peek     (peek),
      .word     (word)
   );

   // word FSM and bit counter
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      shift_en = 1'b0;
      clr      = 1'b0;
      complete = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         clr     = 1'b1;
      end else if (sin_valid) begin
         unique case (state_q)
            IDLE: begin
               dir_d    = dir;
               shift_en = 1'b1;
               cnt_d    = CNT_W'(1);
               state_d  = DATA;
            end
            DATA: begin
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef USR_DESER_PARITY_EN
                  shift_en = 1'b1;
                  cnt_d    = CNT_W'(WIDTH);
                  state_d  = PAR;
`else
                  complete = 1'b1;
                  clr      = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
`endif
               end else begin
                  shift_en = 1'b1;
                  cnt_d    = cnt_q + CNT_W'(1);
               end
            end
            default: begin
`ifdef USR_DESER_PARITY_EN
               complete = 1'b1;
               clr      = 1'b1;
`endif
               cnt_d    = '0;
               state_d  = IDLE;
            end
         endcase
      end
   end

   // output word handshake and sticky overrun
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
      if (ovr_clr) begin
         overrun_d = 1'b0;
      end
      if (complete) begin
         if (dout_valid_q && !dout_ready) begin
            overrun_d = 1'b1;
         end else begin
            dout_d       = word;
            dout_valid_d = 1'b1;
         end
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dir_q        <= DIR_MSB;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dir_q        <= dir_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef USR_DESER_PARITY_EN
   logic par_q;
   logic par_d;

   // parity result follows dout: only updated when a word is loaded
   always_comb begin
      par_d = par_q;
      if (complete && !(dout_valid_q && !dout_ready)) begin
         par_d = (^word) ^ sin;
      end
   end

   // parity flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign parity_err = par_q & dout_valid_q;
`else
   assign parity_err = 1'b0;
`endif

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign bit_cnt    = cnt_q;
   assign overrun    = overrun_q;

endmodule
